dds_key_dec: RTL and testbench
==============================

// Module: dds_key_dec
// PURPOSE
//  Consumes the 4-bit one-hot key command produced by the debounced key controller and
//  turns it into DDS settings: waveform select, frequency tuning word, step size.
//  Sits between key control and the DDS phase accumulator / waveform ROM.
//  Issues exactly one action per press, plus optional hold-to-repeat.
// PARAMETERS
//  FW          32          tuning-word width
//  FW_INIT     32'd85899   tuning word after reset
//  FW_MIN      32'd1       lower saturation limit of freq_word
//  FW_MAX      32'h7FFFFFFF upper saturation limit of freq_word
//  STEP_BASE   32'd8590    step for step_idx 0; step = STEP_BASE << (2*step_idx)
//  REPEAT_DLY  24'd500     hold cycles before the first repeat (repeat option only)
//  REPEAT_PER  24'd100     cycles between repeats (repeat option only)
// PORTS
//  clk         in   1    system clock
//  rstn        in   1    asynchronous active-low reset
//  key_cmd     in   4    one-hot command: [0] wave, [1] freq up, [2] freq down, [3] step
//  wave_sel    out  2    0 sine, 1 square, 2 triangle, 3 sawtooth
//  freq_word   out  FW   DDS tuning word
//  step_idx    out  2    current step index 0..3
//  upd         out  1    one-cycle pulse on the edge any output changes
// BEHAVIOUR
//  - Reset (async, rstn=0): wave_sel=0, freq_word=FW_INIT, step_idx=0, upd=0, cmd_q=0,
//    FSM=IDLE, repeat counter=0. Reset mid-hold abandons the hold; no action on release.
//  - key_cmd is a valid command only when exactly one bit is set; 0000 and multi-hot
//    are treated as "no key" (multi-hot never triggers an action).
//  - cmd_q registers the last valid command (0 if none). A press = valid key_cmd at an
//    edge where key_cmd != cmd_q. Action applies at that same edge: outputs and upd=1
//    are visible after the edge (latency 1 clock from input to output).
//  - Direct change between two valid commands (e.g. 0001->0010) counts as a new press.
//  - Actions: [0] wave_sel <= wave_sel+1 (wraps 3->0); [3] step_idx <= step_idx+1 (wraps 3->0);
//    [1] freq_word <= min(freq_word+step, FW_MAX); [2] freq_word <= max(freq_word-step, FW_MIN).
//    Arithmetic in FW+1 bits; overflow/underflow saturates at the limits, never wraps.
//  - upd pulses only when an action is applied, including a saturated up/down
//    that leaves freq_word unchanged.
//  - FSM: IDLE -(press)-> HOLD; HOLD -(key_cmd==cmd_q)-> HOLD;
//    HOLD -(no key)-> IDLE, cmd_q<=0; HOLD -(other valid cmd)-> HOLD with new action.
//    REPEAT state exists only with the repeat option (below).
//  - Holding the same command produces no further actions without the repeat option.
// CONFIGURATION
//  DDS_KEY_REPEAT_EN defined: in HOLD with cmd_q = [1] or [2], counter runs; at
//    REPEAT_DLY cycles -> REPEAT, one extra up/down action; then one action every
//    REPEAT_PER cycles while held. Release -> IDLE; counter clears on any press/release.
//    Wave and step commands never repeat.
//  DDS_KEY_REPEAT_EN undefined: no counter, no REPEAT state, REPEAT_* parameters unused.
// TESTING
//  1 reset: rstn low 3 cycles -> wave_sel=0, freq_word=FW_INIT, step_idx=0, upd=0.
//  2 key_cmd=0001 for 10 cycles, then 0 -> wave_sel 0->1 once, upd high exactly 1 cycle;
//    four presses -> wave_sel back to 0.
//  3 step press x1 then up press -> step_idx=1, freq_word=FW_INIT+34360; down press
//    -> back to FW_INIT.
//  4 saturation: freq_word near FW_MAX, up press -> freq_word=FW_MAX, upd=1; down presses
//    near FW_MIN -> freq_word=FW_MIN, never wraps.
//  5 key_cmd=0011 or 0110 held 20 cycles -> no output change, upd stays 0; 0001->0010
//    directly -> wave and frequency actions on consecutive edges.
//  6 DDS_KEY_REPEAT_EN, REPEAT_DLY=10, REPEAT_PER=4, hold 0010 for 30 cycles -> actions at
//    cycles 0, 10, 14, 18, 22, 26; rstn pulse at cycle 15 -> outputs at reset values,
//    no action until release-then-press.

Source files
------------

// File: rtl/dds_key_dec_if.sv
// dds_key_dec_if: key command in, DDS settings out, between key control and the DDS core.
// The master modport is the key/DDS side; the slave modport is the decoder itself.
interface dds_key_dec_if #(
    parameter int FW = 32
);
    logic [3:0]    key_cmd;
    logic [1:0]    wave_sel;
    logic [FW-1:0] freq_word;
    logic [1:0]    step_idx;
    logic          upd;

    modport master (
        output key_cmd,
        input  wave_sel,
        input  freq_word,
        input  step_idx,
        input  upd
    );

    modport slave (
        input  key_cmd,
        output wave_sel,
        output freq_word,
        output step_idx,
        output upd
    );
endinterface

// File: rtl/dds_key_dec.sv
// dds_key_dec: turns one-hot debounced key commands into DDS wave/frequency/step settings.
// Define DDS_KEY_REPEAT_EN to add hold-to-repeat for the frequency up/down keys.
module dds_key_dec #(
    parameter int            FW        = 32,
    parameter logic [FW-1:0] FW_INIT   = 32'd85899,
    parameter logic [FW-1:0] FW_MIN    = 32'd1,
    parameter logic [FW-1:0] FW_MAX    = 32'h7FFFFFFF,
    parameter logic [FW-1:0] STEP_BASE = 32'd8590
`ifdef DDS_KEY_REPEAT_EN
    ,
    parameter logic [23:0]   REPEAT_DLY = 24'd500,
    parameter logic [23:0]   REPEAT_PER = 24'd100
`endif
) (
    input logic          clk,
    input logic          rstn,
    dds_key_dec_if.slave bus
);

    localparam logic [3:0] CMD_WAVE = 4'b0001;
    localparam logic [3:0] CMD_UP   = 4'b0010;
    localparam logic [3:0] CMD_DOWN = 4'b0100;
    localparam logic [3:0] CMD_STEP = 4'b1000;

`ifdef DDS_KEY_REPEAT_EN
    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
`else
    typedef enum logic [0:0] {IDLE, HOLD} state_t;
`endif

    state_t        state;
    logic [3:0]    cmd_q;
    logic          lock;
    logic [1:0]    wave_sel;
    logic [1:0]    step_idx;
    logic [FW-1:0] freq_word;
    logic          upd;

    logic [3:0]    key_cmd;
    logic          key_valid;
    logic          press;
    logic [3:0]    act;
    logic [FW-1:0] step_val;
    logic [FW:0]   sum;
    logic [FW:0]   diff;
    logic [FW-1:0] fw_up;
    logic [FW-1:0] fw_dn;

`ifdef DDS_KEY_REPEAT_EN
    logic [23:0]   rpt_cnt;
    logic          rpt_cmd;
    logic          rpt_fire;
`endif

    assign key_cmd       = bus.key_cmd;
    assign bus.wave_sel  = wave_sel;
    assign bus.freq_word = freq_word;
    assign bus.step_idx  = step_idx;
    assign bus.upd       = upd;

    // Arithmetic is one bit wider than the tuning word so over/underflow saturates instead of wrapping.
    always_comb begin
        key_valid = $onehot(key_cmd);
        press     = key_valid && !lock && (key_cmd != cmd_q);
        step_val  = STEP_BASE << {step_idx, 1'b0};
        sum       = {1'b0, freq_word} + {1'b0, step_val};
        diff      = {1'b0, freq_word} - {1'b0, step_val};
        fw_up     = (sum > {1'b0, FW_MAX}) ? FW_MAX : sum[FW-1:0];
        fw_dn     = (diff[FW] || (diff[FW-1:0] < FW_MIN)) ? FW_MIN : diff[FW-1:0];
        act       = press ? key_cmd : 4'b0000;
`ifdef DDS_KEY_REPEAT_EN
        rpt_cmd   = key_valid && (key_cmd == cmd_q) && ((cmd_q == CMD_UP) || (cmd_q == CMD_DOWN));
        rpt_fire  = rpt_cmd &&
                    (((state == HOLD)   && (rpt_cnt == REPEAT_DLY - 24'd1)) ||
                     ((state == REPEAT) && (rpt_cnt == REPEAT_PER - 24'd1)));
        if (rpt_fire) begin
            act = cmd_q;
        end
`endif
    end

    // lock is set by reset so a key still held across reset must be released before it acts again.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cmd_q     <= 4'b0000;
            lock      <= 1'b1;
            wave_sel  <= 2'd0;
            step_idx  <= 2'd0;
            freq_word <= FW_INIT;
            upd       <= 1'b0;
`ifdef DDS_KEY_REPEAT_EN
            rpt_cnt   <= 24'd0;
`endif
        end else begin
            upd <= |act;
            if (!key_valid) begin
                lock <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (press) begin
                        state <= HOLD;
                        cmd_q <= key_cmd;
                    end
                end
                HOLD: begin
                    if (!key_valid) begin
                        state <= IDLE;
                        cmd_q <= 4'b0000;
                    end else if (press) begin
                        cmd_q <= key_cmd;
`ifdef DDS_KEY_REPEAT_EN
                    end else if (rpt_fire) begin
                        state <= REPEAT;
`endif
                    end
                end
`ifdef DDS_KEY_REPEAT_EN
                REPEAT: begin
                    if (!key_valid) begin
                        state <= IDLE;
                        cmd_q <= 4'b0000;
                    end else if (press) begin
                        state <= HOLD;
                        cmd_q <= key_cmd;
                    end
                end
`endif
                default: state <= IDLE;
            endcase

`ifdef DDS_KEY_REPEAT_EN
            if (press || !rpt_cmd || rpt_fire) begin
                rpt_cnt <= 24'd0;
            end else begin
                rpt_cnt <= rpt_cnt + 24'd1;
            end
`endif

            case (act)
                CMD_WAVE: wave_sel  <= wave_sel + 2'd1;
                CMD_UP:   freq_word <= fw_up;
                CMD_DOWN: freq_word <= fw_dn;
                CMD_STEP: step_idx  <= step_idx + 2'd1;
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_dds_key_dec.sv
// tb_dds_key_dec: directed self-checking bench for dds_key_dec with hand-computed expectations.
// Define DDS_KEY_REPEAT_EN for both files to exercise hold-to-repeat with short delays.
module tb_dds_key_dec;

    localparam int          FW      = 32;
    localparam logic [31:0] FW_INIT = 32'd85899;
    localparam logic [31:0] FW_MIN  = 32'd1;
    localparam logic [31:0] FW_MAX  = 32'h7FFFFFFF;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   updCount;
    logic updSeen;
    logic [31:0] updMask;
    logic [31:0] expMask;

    dds_key_dec_if #(.FW(FW)) bus ();

    dds_key_dec #(
        .FW(FW)
`ifdef DDS_KEY_REPEAT_EN
        ,
        .REPEAT_DLY(24'd10),
        .REPEAT_PER(24'd4)
`endif
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Every stimulus task starts and ends on a falling edge, so outputs are sampled mid-cycle.
    task automatic applyStimulus(input logic [3:0] cmd, input int cycles, output int updN);
        updN = 0;
        bus.key_cmd = cmd;
        repeat (cycles) begin
            @(negedge clk);
            if (bus.upd === 1'b1) updN++;
        end
    endtask

    task automatic pressKey(input logic [3:0] cmd, output logic updOut);
        bus.key_cmd = cmd;
        @(negedge clk);
        updOut = bus.upd;
        bus.key_cmd = 4'b0000;
        @(negedge clk);
    endtask

    task automatic doReset();
        bus.key_cmd = 4'b0000;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bus.key_cmd = 4'b0000;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_wave", 32'(bus.wave_sel), 32'd0);
        checkOutput("reset_freq", bus.freq_word, FW_INIT);
        checkOutput("reset_step", 32'(bus.step_idx), 32'd0);
        checkOutput("reset_upd", 32'(bus.upd), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Wave key held 10 cycles: one action only.
        applyStimulus(4'b0001, 10, updCount);
        checkOutput("wave_hold_upd", updCount, 1);
        checkOutput("wave_hold_sel", 32'(bus.wave_sel), 32'd1);
        applyStimulus(4'b0000, 1, updCount);
        checkOutput("wave_release_upd", updCount, 0);
        pressKey(4'b0001, updSeen);
        checkOutput("wave_press2_upd", 32'(updSeen), 32'd1);
        pressKey(4'b0001, updSeen);
        pressKey(4'b0001, updSeen);
        checkOutput("wave_wrap", 32'(bus.wave_sel), 32'd0);

        // Step 1 then up and down by 34360.
        pressKey(4'b1000, updSeen);
        checkOutput("step_upd", 32'(updSeen), 32'd1);
        checkOutput("step_idx1", 32'(bus.step_idx), 32'd1);
        pressKey(4'b0010, updSeen);
        checkOutput("up_step1", bus.freq_word, 32'd120259);
        pressKey(4'b0100, updSeen);
        checkOutput("down_step1", bus.freq_word, FW_INIT);

        // Step 3 (549760), climb to just below FW_MAX, then saturate.
        pressKey(4'b1000, updSeen);
        pressKey(4'b1000, updSeen);
        checkOutput("step_idx3", 32'(bus.step_idx), 32'd3);
        for (int i = 0; i < 3906; i++) pressKey(4'b0010, updSeen);
        checkOutput("up_near_max", bus.freq_word, 32'd2147448459);
        pressKey(4'b0010, updSeen);
        checkOutput("sat_max_upd", 32'(updSeen), 32'd1);
        checkOutput("sat_max_freq", bus.freq_word, FW_MAX);
        pressKey(4'b0010, updSeen);
        checkOutput("sat_max_again_upd", 32'(updSeen), 32'd1);
        checkOutput("sat_max_again_freq", bus.freq_word, FW_MAX);
        pressKey(4'b0100, updSeen);
        checkOutput("down_from_max", bus.freq_word, 32'd2146933887);

        // Reset, step 3, down saturates at FW_MIN.
        doReset();
        checkOutput("reset2_freq", bus.freq_word, FW_INIT);
        checkOutput("reset2_step", 32'(bus.step_idx), 32'd0);
        for (int i = 0; i < 3; i++) pressKey(4'b1000, updSeen);
        pressKey(4'b0100, updSeen);
        checkOutput("sat_min_upd", 32'(updSeen), 32'd1);
        checkOutput("sat_min_freq", bus.freq_word, FW_MIN);
        pressKey(4'b0100, updSeen);
        checkOutput("sat_min_again_upd", 32'(updSeen), 32'd1);
        checkOutput("sat_min_again_freq", bus.freq_word, FW_MIN);

        // Multi-hot never acts.
        applyStimulus(4'b0011, 20, updCount);
        checkOutput("multi_0011_upd", updCount, 0);
        applyStimulus(4'b0110, 20, updCount);
        checkOutput("multi_0110_upd", updCount, 0);
        checkOutput("multi_freq", bus.freq_word, FW_MIN);
        checkOutput("multi_wave", 32'(bus.wave_sel), 32'd0);
        applyStimulus(4'b0000, 1, updCount);

        // Direct 0001 -> 0010: actions on consecutive edges.
        applyStimulus(4'b0001, 1, updCount);
        checkOutput("direct_wave_upd", updCount, 1);
        checkOutput("direct_wave_sel", 32'(bus.wave_sel), 32'd1);
        applyStimulus(4'b0010, 1, updCount);
        checkOutput("direct_up_upd", updCount, 1);
        checkOutput("direct_up_freq", bus.freq_word, 32'd549761);
        applyStimulus(4'b0000, 1, updCount);

`ifdef DDS_KEY_REPEAT_EN
        // Hold up for 30 cycles: actions at 0, 10, 14, 18, 22, 26.
        doReset();
        expMask = 32'h0444_4401;
        updMask = 32'd0;
        bus.key_cmd = 4'b0010;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            updMask[i] = bus.upd;
        end
        bus.key_cmd = 4'b0000;
        @(negedge clk);
        checkOutput("repeat_mask", updMask, expMask);
        checkOutput("repeat_freq", bus.freq_word, 32'd137439);

        // Reset mid-hold at cycle 15, key kept held.
        doReset();
        expMask = 32'h0000_4401;
        updMask = 32'd0;
        bus.key_cmd = 4'b0010;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            updMask[i] = bus.upd;
        end
        checkOutput("repeat_pre_reset_mask", updMask, expMask);
        rstn = 1'b0;
        @(negedge clk);
        checkOutput("midhold_reset_freq", bus.freq_word, FW_INIT);
        checkOutput("midhold_reset_upd", 32'(bus.upd), 32'd0);
        rstn = 1'b1;
        applyStimulus(4'b0010, 14, updCount);
        checkOutput("after_reset_hold_upd", updCount, 0);
        checkOutput("after_reset_hold_freq", bus.freq_word, FW_INIT);
        applyStimulus(4'b0000, 1, updCount);
        pressKey(4'b0010, updSeen);
        checkOutput("repress_upd", 32'(updSeen), 32'd1);
        checkOutput("repress_freq", bus.freq_word, 32'd94489);
`else
        // Without repeat, holding up for 30 cycles acts once.
        doReset();
        applyStimulus(4'b0010, 30, updCount);
        checkOutput("hold_norepeat_upd", updCount, 1);
        checkOutput("hold_norepeat_freq", bus.freq_word, 32'd94489);
        applyStimulus(4'b0000, 1, updCount);

        // Reset mid-hold: held key is ignored until released.
        applyStimulus(4'b0001, 3, updCount);
        rstn = 1'b0;
        @(negedge clk);
        checkOutput("midhold_reset_wave", 32'(bus.wave_sel), 32'd0);
        rstn = 1'b1;
        applyStimulus(4'b0001, 5, updCount);
        checkOutput("after_reset_hold_upd", updCount, 0);
        checkOutput("after_reset_hold_wave", 32'(bus.wave_sel), 32'd0);
        applyStimulus(4'b0000, 1, updCount);
        pressKey(4'b0001, updSeen);
        checkOutput("repress_upd", 32'(updSeen), 32'd1);
        checkOutput("repress_wave", 32'(bus.wave_sel), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
